// File: rtl/seg_scan_display.sv
// Multi-digit seven-segment driver: double-dabble binary-to-BCD converter plus anode/segment scanner.
// Optional SEG_LZ_BLANK_EN blanks digits above the most significant nonzero digit.
module seg_scan_display #(
  parameter int DIGITS      = 4,
  parameter int VAL_W       = 10,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int BCD_W = 4 * DIGITS + 4;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state_reg, state_next;
  logic [VAL_W-1:0]    bin_reg, bin_next;
  logic [BCD_W-1:0]    bcd_reg, bcd_next, bcd_adj;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ovf_pend_reg, ovf_pend_next;
  logic [4*DIGITS-1:0] disp_reg, disp_next;
  logic                overflow_reg, overflow_next;

  // Add-3 correction applied to every nibble before each shift
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      disp_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      bcd_reg      <= bcd_next;
      cnt_reg      <= cnt_next;
      ovf_pend_reg <= ovf_pend_next;
      disp_reg     <= disp_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    ovf_pend_next = ovf_pend_reg;
    disp_next     = disp_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          bin_next      = value;
          bcd_next      = '0;
          cnt_next      = CNT_W'(VAL_W);
          ovf_pend_next = (64'(value) >= LIMIT);
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) state_next = COMMIT;
      end
      COMMIT: begin
        disp_next     = bcd_reg[4*DIGITS-1:0];
        overflow_next = ovf_pend_reg;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign overflow = overflow_reg;

  // Per-digit segment pattern; leading-zero blanking never touches digit 0
  logic [DIGITS-1:0] lz_blank;
  logic [6:0]        digit_seg [DIGITS];

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
`ifdef SEG_LZ_BLANK_EN
        assign lz_blank[gi] = (disp_reg[4*DIGITS-1:4*gi] == '0);
`else
        assign lz_blank[gi] = 1'b0;
`endif
      end
      assign digit_seg[gi] = overflow_reg   ? 7'b0111111 :
                             lz_blank[gi]   ? 7'b1111111 :
                             dec7(disp_reg[gi*4 +: 4]);
    end
  endgenerate

  logic [REF_W-1:0]  ref_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DIGITS-1:0] an_reg;
  logic [6:0]        seg_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_reg <= '0;
      idx_reg <= '0;
      an_reg  <= '1;
      seg_reg <= 7'b1111111;
    end else begin
      if (ref_reg == REF_W'(REFRESH_DIV - 1)) begin
        ref_reg <= '0;
        idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        ref_reg <= ref_reg + REF_W'(1);
      end
      an_reg  <= ~(DIGITS'(1) << idx_reg);
      seg_reg <= digit_seg[idx_reg];
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multi-digit seven-segment score display driver. It captures a binary value on a load pulse and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It commits the digits atomically to a display register and time-multiplexes them onto shared anode/segment lines. It sits between the game score counter and the board's seven-segment pins, and generalises the fixed 4-digit score display to any digit count and value width, adding overflow indication and optional leading-zero blanking.

## Interface
- `DIGITS`, 4, number of displayed digits (1..8)
- `VAL_W`, 10, width of the binary input value (1..27)
- `REFRESH_DIV`, 100000, clock cycles each digit stays lit (≥2)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `value`  in  VAL_W  unsigned binary value to display
- `load`  in  1  single-cycle request to convert and display `value`
- `busy`  out  1  conversion in progress; `load` ignored while high
- `overflow`  out  1  last committed value was ≥ 10^DIGITS
- `an`  out  DIGITS  digit enables, one-hot active-low, `an[0]` = least significant digit
- `seg`  out  7  segments, active-low, `seg[0]`=a … `seg[6]`=g

## Operation
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: when `load`=1, capture `value` into the shift register, clear the BCD accumulator, set the iteration count to VAL_W, compute `ovf_pend = (value >= 10^DIGITS)`, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. Decrement the count. After the VAL_W-th shift, go to COMMIT.
  - COMMIT: copy the low 4*DIGITS BCD bits into the display register, copy `ovf_pend` into `overflow`, and go to IDLE.
- Accumulator width is 4*DIGITS+4 bits. Nibbles above DIGITS are discarded at commit.
- `load` in SHIFT or COMMIT is dropped. It is not queued.
- Scanner runs independently of the converter:
  - The refresh counter counts 0..REFRESH_DIV-1. At terminal count the digit index advances: 0→1→…→DIGITS-1→0.
  - `an` and `seg` are registered from the current index and the display register.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank is 1111111.
- When `overflow`=1, every digit shows a dash (0111111) regardless of BCD content.

## Timing
- Reset values:
  - `an`=all ones, `seg`=1111111, `busy`=0, `overflow`=0.
  - Display register all zero, digit index 0, refresh counter 0, FSM IDLE.
- On the first rising edge after `rst` deasserts, `an`=…1110 and `seg` shows digit 0.
- `load` sampled high at edge t (IDLE):
  - `busy`=1 from t+1 through t+VAL_W+1.
  - Display register and `overflow` are updated at edge t+VAL_W+1.
  - `busy`=0 from t+VAL_W+2. A new `load` is accepted at that edge.
- The new digits appear on `seg` one cycle after the display register update, within the currently lit slot (no tearing: all digits change on the same edge).
- Scan period is DIGITS*REFRESH_DIV cycles. Each `an` pattern is held for exactly REFRESH_DIV cycles.
- `rst` asserted mid-conversion: the conversion is aborted immediately, and all state returns to reset values. The previous display content is lost.
- `load` and terminal refresh count in the same cycle: both act. There is no interaction.

## Configuration
- `SEG_LZ_BLANK_EN` defined: any digit above the most significant nonzero digit shows blank (1111111). Digit 0 is never blanked, so value 0 shows "0". Overflow dashes override blanking.
- Not defined: all DIGITS digits are shown, including leading zeros.

## Test plan
- Use DIGITS=4, VAL_W=10, REFRESH_DIV=4 unless stated.
- Reset: hold `rst`=0 → `an`=1111, `seg`=1111111, `busy`=0. Release → next edge `an`=1110, `seg`=1000000.
- Conversion: pulse `load` with `value`=937 → `busy` high exactly 11 cycles. Then digits 0..3 = 7,3,9,0. Digit 3 `seg`=1000000 without the macro and 1111111 with it.
- Overflow: DIGITS=3, `load` with `value`=1023 → `overflow`=1, all three digits `seg`=0111111. Then `load` with `value`=5 → `overflow`=0, digit 0 `seg`=0010010.
- Load while busy: `load` 937, then `load` 12 two cycles later → display settles to 937 and 12 is never shown. Then `load` 12 after `busy` falls → display shows 12.
- Scan wrap: with idle input, `an` sequence is 1110,1101,1011,0111,1110, each held exactly 4 cycles.
- Mid-conversion reset: assert `rst` 5 cycles after `load` of 937 → all outputs take reset values asynchronously. After release the display shows 0 and `busy`=0.
